move_ctrl: RTL



---
 rtl/move_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/move_ctrl.sv
// Direction-pulse consumer: queues L/R/U/D requests and steps the head
// position one cell per game tick with wrap-around at the grid edges.
module move_ctrl #(
   parameter int unsigned GRID_W   = 16,
   parameter int unsigned GRID_H   = 12,
   parameter int unsigned TICK_DIV = 25_000_000,
   parameter int unsigned QDEPTH   = 4,
   parameter int unsigned X0       = 8,
   parameter int unsigned Y0       = 6
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       L,
   input  logic       R,
   input  logic       U,
   input  logic       D,
   input  logic       pause,
   output logic [7:0] pos_x,
   output logic [7:0] pos_y,
   output logic [1:0] dir,
   output logic       tick,
   output logic [3:0] q_count,
   output logic       drop
);

   localparam int unsigned CW = $clog2(TICK_DIV);
   localparam int unsigned PW = $clog2(QDEPTH);

   localparam logic [1:0] DIR_U = 2'd0;
   localparam logic [1:0] DIR_R = 2'd1;
   localparam logic [1:0] DIR_D = 2'd2;
   localparam logic [1:0] DIR_L = 2'd3;

   logic [CW-1:0] cnt;
   logic [1:0]    mem [QDEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   logic [2:0] n_pulse;
   logic [1:0] cand;
   logic [1:0] ref_dir;
   logic [1:0] new_dir;
   logic       single;
   logic       multi;
   logic       empty;
   logic       full;
   logic       move_edge;
   logic       pop;
   logic       push;
   logic       is_opp;
   logic       is_same;
   logic       drop_n;
   logic [7:0] next_x;
   logic [7:0] next_y;

   // Request decode and admission against the pre-pop tail
   always_comb begin
      n_pulse   = 3'(L) + 3'(R) + 3'(U) + 3'(D);
      single    = (n_pulse == 3'd1);
      multi     = (n_pulse > 3'd1);
      cand      = DIR_U;
      if (R)      cand = DIR_R;
      else if (D) cand = DIR_D;
      else if (L) cand = DIR_L;
      empty     = (q_count == 4'd0);
      full      = (q_count == 4'(QDEPTH));
      ref_dir   = empty ? dir : mem[wr_ptr - PW'(1)];
      move_edge = !pause && (cnt == CW'(TICK_DIV - 1));
      pop       = move_edge && !empty;
      is_opp    = (cand == (ref_dir ^ 2'b10));
      is_same   = (cand == ref_dir);
      push      = single && !is_opp && !is_same && (!full || pop);
      drop_n    = multi || (single && is_opp) ||
                  (single && !is_opp && !is_same && full && !pop);
      new_dir   = pop ? mem[rd_ptr] : dir;
   end

   // One-cell step in the new direction with edge wrap
   always_comb begin
      next_x = pos_x;
      next_y = pos_y;
      case (new_dir)
         DIR_U:   next_y = (pos_y == 8'd0) ? 8'(GRID_H - 1) : pos_y - 8'd1;
         DIR_R:   next_x = (pos_x == 8'(GRID_W - 1)) ? 8'd0 : pos_x + 8'd1;
         DIR_D:   next_y = (pos_y == 8'(GRID_H - 1)) ? 8'd0 : pos_y + 8'd1;
         default: next_x = (pos_x == 8'd0) ? 8'(GRID_W - 1) : pos_x - 8'd1;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         cnt <= '0;
      end else if (!pause) begin
         cnt <= (cnt == CW'(TICK_DIV - 1)) ? '0 : cnt + CW'(1);
      end
   end

   // FIFO storage needs no reset: occupancy gates every read
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= cand;
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         q_count <= 4'd0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   q_count <= q_count + 4'd1;
            2'b01:   q_count <= q_count - 4'd1;
            default: q_count <= q_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         pos_x <= 8'(X0);
         pos_y <= 8'(Y0);
         dir   <= DIR_R;
         tick  <= 1'b0;
         drop  <= 1'b0;
      end else begin
         tick <= move_edge;
         drop <= drop_n;
         if (move_edge) begin
            dir   <= new_dir;
            pos_x <= next_x;
            pos_y <= next_y;
         end
      end
   end

endmodule
